ascon_sca_stim_driver: RTL
==========================

Name: ascon_sca_stim_driver

Overview:
- Synthesizable stimulus sequencer for the masked Ascon core (ascon_core_sca), generalised to any share count.
- Consumes an INS/DAT command stream and splits each DAT word into NUM_SHARES Boolean shares using an external randomness input.
- Drives the core's key/bdi handshakes, and recombines the core's bdo shares into unmasked results.
- Lets the same command-stream vectors run on silicon/FPGA and in simulation.

Parameters:
- NUM_SHARES, 2: number of Boolean shares; must be ≥1.
- CCW, 32: bdi/bdo width per share.
- CCSW, 32: key width per share.
- LEN_W, 24: byte-length field width in an INS word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command word valid
- cmd_ready  out  1  command word accepted
- cmd_is_ins  in  1  1 = INS word, 0 = DAT word
- cmd_data  in  32  INS: op[31:28], flags[27:24], len[23:0] bytes; DAT: payload
- rnd  in  (NUM_SHARES-1)*CCW  fresh mask bits, sampled on each DAT accept
- key  out  NUM_SHARES*CCSW  shared key word
- key_valid  out  1  key word valid
- key_ready  in  1  key word accepted by core
- bdi  out  NUM_SHARES*CCW  shared block-data word
- bdi_valid  out  1  block-data word valid
- bdi_ready  in  1  block-data word accepted by core
- bdi_type  out  4  D_NONCE/D_AD/D_PTCT/D_TAG/D_NULL
- bdi_eot  out  1  last word of the current type
- bdi_eoi  out  1  last input of the operation
- decrypt  out  1  mode flag to core
- hash  out  1  mode flag to core
- bdo  in  NUM_SHARES*CCW  shared core output
- bdo_valid  in  1  core output valid
- bdo_ready  out  1  core output accepted
- bdo_type  in  4  type of core output
- auth  in  1  tag verification result
- auth_valid  in  1  verification result valid
- auth_ready  out  1  verification result accepted
- res_valid  out  1  unmasked result valid
- res_ready  in  1  result consumer ready
- res_data  out  CCW  XOR of all bdo shares
- res_type  out  4  latched bdo_type
- auth_ok  out  1  sticky last auth value
- proto_err  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - All valid/ready outputs 0; decrypt=hash=0; bdi_type=D_NULL.
  - words_left=0, auth_ok=0, proto_err=0, FSM=IDLE.
  - Reset mid-transfer drops the held word and the held result with no completion.
- FSM states:
  - IDLE: cmd_ready=1.
    - INS with op in {OP_DO_ENC, OP_DO_DEC, OP_DO_HASH}: register decrypt/hash next cycle (ENC 0/0, DEC 1/0, HASH 0/1); stay in IDLE.
    - INS with an OP_LD_* op and len>0: words_left=ceil(len/4), latch op and flags; go to LOAD.
    - LD op with len=0: consumed, no transfer.
    - DAT word in IDLE: consumed, proto_err<=1.
  - LOAD: cmd_ready = !out_valid | out_fire.
    - On DAT accept: form shares into the output register.
      - Share i≥1 = rnd slice i-1; share0 = data ^ XOR of all rnd slices.
      - For NUM_SHARES=1, share0 = data.
      - Key ops zero-extend or truncate data to CCSW.
    - Type from op: NONCE, AD, PTCT (PT/CT), TAG.
    - eot=1 when words_left==1; eoi=flags[0] on that word; words_left decrements on accept.
    - When the last word fires, go to IDLE.
    - INS received in LOAD: proto_err<=1; the INS is consumed and handled as in IDLE; any held word is discarded.
- Output hold: key/bdi, type, eot and eoi stay stable while valid & !ready. Fire = valid & ready, same cycle.
  - key_valid is asserted only for OP_LD_KEY; bdi_valid only for the other loads.
  - Back-to-back words at 1 word/cycle when the core stays ready.
- Result path (independent of the FSM):
  - bdo_ready = !res_valid | res_ready.
  - On bdo fire: res_data <= XOR of shares, res_type <= bdo_type, res_valid <= 1. Latency 1 cycle.
  - res_valid clears on res fire unless refilled in the same cycle.
- Auth: auth_ready=1 always. On auth_valid: auth_ok <= auth.

Decomposition:
- OP_* codes, D_* type codes and the cmd field offsets go in the shared config package; reuse the existing codes, do not redefine them.
- Sub-module ascon_share_split (combinational share formation, NUM_SHARES-generic).
- Recombination XOR is inline.

Test Plan:
- NUM_SHARES=2, core always ready: INS LD_KEY len=16 plus 4 DAT words → 4 consecutive key fires. Each word's share0^share1 equals its data; eot only on word 4.
- INS LD_NONCE len=16, bdi_ready toggling 1/0 → bdi and eot held stable through stalls; exactly 4 fires; return to IDLE.
- INS LD_AD len=5, flags=1 → 2 words; second word has eot=1 and eoi=1, type D_AD.
- bdo shares 0xA5A5A5A5 / 0x0F0F0F0F with res_ready=0 for 3 cycles → res_data=0xAAAAAAAA, held stable; bdo_ready=0 until consumed.
- DAT word in IDLE, then INS mid-load → proto_err=1 and sticky; new INS takes effect.
- rst asserted with a held bdi word → next cycle all valids 0, words_left 0.

Source files
------------

// File: rtl/ascon_sca_stim_driver_pkg.sv
// Shared command-stream codes, core data-type codes and FSM encodings for the stimulus driver.
package ascon_sca_stim_driver_pkg;

    // INS opcodes (cmd_data[31:28])
    localparam logic [3:0] OP_LD_KEY   = 4'h1;
    localparam logic [3:0] OP_LD_NONCE = 4'h2;
    localparam logic [3:0] OP_LD_AD    = 4'h3;
    localparam logic [3:0] OP_LD_PT    = 4'h4;
    localparam logic [3:0] OP_LD_CT    = 4'h5;
    localparam logic [3:0] OP_LD_TAG   = 4'h6;
    localparam logic [3:0] OP_DO_ENC   = 4'h8;
    localparam logic [3:0] OP_DO_DEC   = 4'h9;
    localparam logic [3:0] OP_DO_HASH  = 4'hA;

    // Core bdi/bdo type codes
    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_PTCT  = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    // INS field offsets
    localparam int unsigned CMD_OP_LSB    = 28;
    localparam int unsigned CMD_FLAGS_LSB = 24;

    // FSM encoding
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StLoad = 1'b1;

    typedef logic [3:0] op_t;

    function automatic logic is_ld_op(input op_t op);
        return (op == OP_LD_KEY) || (op == OP_LD_NONCE) || (op == OP_LD_AD) ||
               (op == OP_LD_PT) || (op == OP_LD_CT) || (op == OP_LD_TAG);
    endfunction

    // Key loads carry no bdi type, so they map to D_NULL.
    function automatic logic [3:0] op_to_type(input op_t op);
        logic [3:0] t;
        case (op)
            OP_LD_NONCE:         t = D_NONCE;
            OP_LD_AD:            t = D_AD;
            OP_LD_PT, OP_LD_CT:  t = D_PTCT;
            OP_LD_TAG:           t = D_TAG;
            default:             t = D_NULL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ascon_sca_stim_driver_share_split.sv
// Combinational Boolean masking: share i>=1 is rnd slice i-1, share 0 absorbs data and all masks.
module ascon_sca_stim_driver_share_split #(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned W          = 32,
    localparam int unsigned RND_W     = (NUM_SHARES > 1) ? (NUM_SHARES - 1) * W : 1
) (
    input  logic [W-1:0]            data_i,
    input  logic [RND_W-1:0]        rnd_i,
    output logic [NUM_SHARES*W-1:0] shares_o
);

    // Share formation; the XOR of all shares always equals data_i.
    always_comb begin
        logic [W-1:0] acc;
        shares_o = '0;
        acc      = data_i;
        for (int i = 1; i < int'(NUM_SHARES); i++) begin
            shares_o[i*W +: W] = rnd_i[(i-1)*W +: W];
            acc                = acc ^ rnd_i[(i-1)*W +: W];
        end
        shares_o[0 +: W] = acc;
    end

endmodule

// File: rtl/ascon_sca_stim_driver.sv
// INS/DAT command sequencer for a masked Ascon core: masks DAT words into shares, drives the
// key/bdi handshakes, and unmasks bdo shares into a one-slot result buffer.
module ascon_sca_stim_driver
    import ascon_sca_stim_driver_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned CCW        = 32,
    parameter int unsigned CCSW       = 32,
    parameter int unsigned LEN_W      = 24,
    localparam int unsigned RND_W     = (NUM_SHARES > 1) ? (NUM_SHARES - 1) * CCW : 1,
    localparam int unsigned KRND_W    = (NUM_SHARES > 1) ? (NUM_SHARES - 1) * CCSW : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_is_ins_i,
    input  logic [31:0]              cmd_data_i,
    input  logic [RND_W-1:0]         rnd_i,
    output logic [NUM_SHARES*CCSW-1:0] key_o,
    output logic                     key_valid_o,
    input  logic                     key_ready_i,
    output logic [NUM_SHARES*CCW-1:0] bdi_o,
    output logic                     bdi_valid_o,
    input  logic                     bdi_ready_i,
    output logic [3:0]               bdi_type_o,
    output logic                     bdi_eot_o,
    output logic                     bdi_eoi_o,
    output logic                     decrypt_o,
    output logic                     hash_o,
    input  logic [NUM_SHARES*CCW-1:0] bdo_i,
    input  logic                     bdo_valid_i,
    output logic                     bdo_ready_o,
    input  logic [3:0]               bdo_type_i,
    input  logic                     auth_i,
    input  logic                     auth_valid_i,
    output logic                     auth_ready_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [CCW-1:0]           res_data_o,
    output logic [3:0]               res_type_o,
    output logic                     auth_ok_o,
    output logic                     proto_err_o
);

    logic [0:0]                 state_q, state_d;
    logic [LEN_W-1:0]           words_left_q, words_left_d;
    op_t                        op_q, op_d;
    logic                       eoi_flag_q, eoi_flag_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_is_key_q, out_is_key_d;
    logic [NUM_SHARES*CCSW-1:0] key_q, key_d;
    logic [NUM_SHARES*CCW-1:0]  bdi_q, bdi_d;
    logic [3:0]                 type_q, type_d;
    logic                       eot_q, eot_d;
    logic                       eoi_q, eoi_d;
    logic                       decrypt_q, decrypt_d;
    logic                       hash_q, hash_d;
    logic                       proto_err_q, proto_err_d;
    logic                       auth_ok_q;
    logic                       res_valid_q;
    logic [CCW-1:0]             res_data_q;
    logic [3:0]                 res_type_q;

    logic                       out_fire, cmd_fire, bdo_fire, res_fire;
    op_t                        cmd_op;
    logic [LEN_W-1:0]           cmd_len;
    logic [KRND_W-1:0]          key_rnd;
    logic [NUM_SHARES*CCSW-1:0] key_shares;
    logic [NUM_SHARES*CCW-1:0]  bdi_shares;
    logic [CCW-1:0]             res_xor;

    assign cmd_op  = cmd_data_i[CMD_OP_LSB +: 4];
    assign cmd_len = cmd_data_i[LEN_W-1:0];

    assign out_fire = out_valid_q & (out_is_key_q ? key_ready_i : bdi_ready_i);

    // LOAD only accepts while words remain; the final held word must drain before IDLE.
    assign cmd_ready_o = ~rst_i & ((state_q == StIdle) ? 1'b1 :
                         ((words_left_q != '0) & (~out_valid_q | out_fire)));
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;

    // Resize each mask slice to the key share width.
    always_comb begin
        key_rnd = '0;
        for (int i = 0; i < int'(NUM_SHARES) - 1; i++) begin
            key_rnd[i*CCSW +: CCSW] = CCSW'(rnd_i[i*CCW +: CCW]);
        end
    end

    ascon_sca_stim_driver_share_split #(
        .NUM_SHARES (NUM_SHARES),
        .W          (CCSW)
    ) u_key_split (
        .data_i   (CCSW'(cmd_data_i)),
        .rnd_i    (key_rnd),
        .shares_o (key_shares)
    );

    ascon_sca_stim_driver_share_split #(
        .NUM_SHARES (NUM_SHARES),
        .W          (CCW)
    ) u_bdi_split (
        .data_i   (CCW'(cmd_data_i)),
        .rnd_i    (rnd_i),
        .shares_o (bdi_shares)
    );

    // Command decode, word loading and output-hold next-state logic.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        op_d         = op_q;
        eoi_flag_d   = eoi_flag_q;
        out_valid_d  = out_valid_q & ~out_fire;
        out_is_key_d = out_is_key_q;
        key_d        = key_q;
        bdi_d        = bdi_q;
        type_d       = type_q;
        eot_d        = eot_q;
        eoi_d        = eoi_q;
        decrypt_d    = decrypt_q;
        hash_d       = hash_q;
        proto_err_d  = proto_err_q;

        if ((state_q == StLoad) && out_fire && (words_left_q == '0)) begin
            state_d = StIdle;
        end

        if (cmd_fire) begin
            if (cmd_is_ins_i) begin
                // An INS mid-load aborts the load and drops any held word.
                if (state_q == StLoad) begin
                    proto_err_d = 1'b1;
                    out_valid_d = 1'b0;
                end
                state_d      = StIdle;
                words_left_d = '0;
                if (cmd_op == OP_DO_ENC) begin
                    decrypt_d = 1'b0;
                    hash_d    = 1'b0;
                end else if (cmd_op == OP_DO_DEC) begin
                    decrypt_d = 1'b1;
                    hash_d    = 1'b0;
                end else if (cmd_op == OP_DO_HASH) begin
                    decrypt_d = 1'b0;
                    hash_d    = 1'b1;
                end else if (is_ld_op(cmd_op) && (cmd_len != '0)) begin
                    op_d         = cmd_op;
                    eoi_flag_d   = cmd_data_i[CMD_FLAGS_LSB];
                    words_left_d = LEN_W'(cmd_len[LEN_W-1:2]) + LEN_W'(|cmd_len[1:0]);
                    state_d      = StLoad;
                end
            end else if (state_q == StIdle) begin
                proto_err_d = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_is_key_d = (op_q == OP_LD_KEY);
                if (op_q == OP_LD_KEY) begin
                    key_d = key_shares;
                end else begin
                    bdi_d = bdi_shares;
                end
                type_d       = op_to_type(op_q);
                eot_d        = (words_left_q == LEN_W'(1));
                eoi_d        = eoi_flag_q & (words_left_q == LEN_W'(1));
                words_left_d = words_left_q - LEN_W'(1);
            end
        end
    end

    // Sequencer and held-word state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            words_left_q <= '0;
            op_q         <= '0;
            eoi_flag_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_is_key_q <= 1'b0;
            key_q        <= '0;
            bdi_q        <= '0;
            type_q       <= D_NULL;
            eot_q        <= 1'b0;
            eoi_q        <= 1'b0;
            decrypt_q    <= 1'b0;
            hash_q       <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            op_q         <= op_d;
            eoi_flag_q   <= eoi_flag_d;
            out_valid_q  <= out_valid_d;
            out_is_key_q <= out_is_key_d;
            key_q        <= key_d;
            bdi_q        <= bdi_d;
            type_q       <= type_d;
            eot_q        <= eot_d;
            eoi_q        <= eoi_d;
            decrypt_q    <= decrypt_d;
            hash_q       <= hash_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = out_valid_q & out_is_key_q;
    assign bdi_o       = bdi_q;
    assign bdi_valid_o = out_valid_q & ~out_is_key_q;
    assign bdi_type_o  = type_q;
    assign bdi_eot_o   = eot_q;
    assign bdi_eoi_o   = eoi_q;
    assign decrypt_o   = decrypt_q;
    assign hash_o      = hash_q;
    assign proto_err_o = proto_err_q;

    // Unmask the core output: XOR of all bdo shares.
    always_comb begin
        res_xor = '0;
        for (int i = 0; i < int'(NUM_SHARES); i++) begin
            res_xor = res_xor ^ bdo_i[i*CCW +: CCW];
        end
    end

    assign bdo_ready_o  = ~rst_i & (~res_valid_q | res_ready_i);
    assign bdo_fire     = bdo_valid_i & bdo_ready_o;
    assign res_fire     = res_valid_q & res_ready_i;
    assign auth_ready_o = ~rst_i;

    // One-slot result buffer and sticky auth result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_type_q  <= D_NULL;
            auth_ok_q   <= 1'b0;
        end else begin
            if (bdo_fire) begin
                res_valid_q <= 1'b1;
                res_data_q  <= res_xor;
                res_type_q  <= bdo_type_i;
            end else if (res_fire) begin
                res_valid_q <= 1'b0;
            end
            if (auth_valid_i) begin
                auth_ok_q <= auth_i;
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_type_o  = res_type_q;
    assign auth_ok_o   = auth_ok_q;

endmodule
